// File: rtl/lsu_dmem_if.sv
// Request/response handshake between the CPU memory stage (master) and the LSU (slave).
interface lsu_dmem_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            req_wen;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_misalign;

    modport master (
        output req_valid, req_addr, req_wdata, req_wen, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_misalign
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wen, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_misalign
    );
endinterface

// File: rtl/lsu_dmem.sv
// Load/store unit in front of a 64-bit-word RAM data port: byte lanes, masks, extension.
// Misaligned accesses are reported in the registered response and never drive the RAM.
module lsu_dmem #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    lsu_dmem_if.slave       bus,
    output logic            o_dmem_en,
    output logic [XLEN-1:0] o_dmem_addr,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [XLEN-1:0] o_dmem_wmask,
    output logic            o_dmem_wen
);

    typedef enum logic {StIdle, StResp} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic            r_resp_misalign;
    logic [XLEN-1:0] r_resp_rdata;

    logic            w_fire;
    logic            w_misalign;
    logic [2:0]      w_off;
    logic [5:0]      w_bit_off;
    logic [7:0]      w_size_bytes;
    logic [7:0]      w_byte_mask;
    logic [XLEN-1:0] w_size_mask;
    logic [XLEN-1:0] w_bit_mask;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_fire) w_state_next = StResp;
            StResp: if (bus.resp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs; no acceptance while reset is held
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (r_state)
            StIdle: bus.req_ready  = ~rst;
            StResp: bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_fire    = bus.req_valid & bus.req_ready;
    assign w_off     = bus.req_addr[2:0];
    assign w_bit_off = {w_off, 3'b000};

    always_comb begin
        w_misalign   = 1'b0;
        w_size_bytes = 8'h01;
        w_size_mask  = XLEN'(64'h0000_0000_0000_00FF);
        unique case (bus.req_size)
            2'd0: begin
                w_misalign   = 1'b0;
                w_size_bytes = 8'h01;
                w_size_mask  = XLEN'(64'h0000_0000_0000_00FF);
            end
            2'd1: begin
                w_misalign   = bus.req_addr[0];
                w_size_bytes = 8'h03;
                w_size_mask  = XLEN'(64'h0000_0000_0000_FFFF);
            end
            2'd2: begin
                w_misalign   = |bus.req_addr[1:0];
                w_size_bytes = 8'h0F;
                w_size_mask  = XLEN'(64'h0000_0000_FFFF_FFFF);
            end
            default: begin
                w_misalign   = |bus.req_addr[2:0];
                w_size_bytes = 8'hFF;
                w_size_mask  = XLEN'(64'hFFFF_FFFF_FFFF_FFFF);
            end
        endcase
    end

    // Aligned accesses never spill past byte 7, so truncating the shift is safe
    assign w_byte_mask = w_size_bytes << w_off;

    always_comb begin
        w_bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_bit_mask[8*i +: 8] = {8{w_byte_mask[i]}};
        end
    end

    assign o_dmem_en    = w_fire & ~w_misalign;
    assign o_dmem_wen   = o_dmem_en & bus.req_wen;
    assign o_dmem_addr  = bus.req_addr;
    assign o_dmem_wdata = o_dmem_en ? ((bus.req_wdata & w_size_mask) << w_bit_off) : '0;
    assign o_dmem_wmask = o_dmem_en ? w_bit_mask : '0;

    assign w_shifted = i_dmem_rdata >> w_bit_off;

    always_comb begin
        w_load_data = w_shifted;
        unique case (bus.req_size)
            2'd0: w_load_data = bus.req_unsigned ? XLEN'(w_shifted[7:0])
                                                 : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_load_data = bus.req_unsigned ? XLEN'(w_shifted[15:0])
                                                 : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_load_data = bus.req_unsigned ? XLEN'(w_shifted[31:0])
                                                 : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_rdata    <= '0;
            r_resp_misalign <= 1'b0;
        end else if (w_fire) begin
            r_resp_misalign <= w_misalign;
            r_resp_rdata    <= (w_misalign | bus.req_wen) ? '0 : w_load_data;
        end
    end

    assign bus.resp_rdata    = r_resp_rdata;
    assign bus.resp_misalign = r_resp_misalign;

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: byte-array reference model, per-cycle compare, directed literal checks.
module tb_lsu_dmem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_dmem_if #(.XLEN(64)) bus ();

    logic        dmem_en;
    logic        dmem_wen;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_rdata;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_wmask;

    lsu_dmem #(.XLEN(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_dmem_en    (dmem_en),
        .o_dmem_addr  (dmem_addr),
        .i_dmem_rdata (dmem_rdata),
        .o_dmem_wdata (dmem_wdata),
        .o_dmem_wmask (dmem_wmask),
        .o_dmem_wen   (dmem_wen)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM environment: 16 words, write commits on the clock edge, combinational read
    logic [63:0] ram [16] = '{default: 64'd0};
    always @(posedge clk) begin
        if (dmem_wen) begin
            ram[dmem_addr[6:3]] <= (ram[dmem_addr[6:3]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
        end
    end
    assign dmem_rdata = ram[dmem_addr[6:3]];

    // Reference model: byte-addressed memory plus one pending-response slot
    logic [7:0]  mdl_mem [128] = '{default: 8'd0};
    logic        mdl_pend  = 1'b0;
    logic [63:0] mdl_rdata = 64'd0;
    logic        mdl_mis   = 1'b0;

    function automatic logic mdl_misaligned(input logic [63:0] a, input logic [1:0] s);
        int n = 1 << s;
        return (int'(a[2:0]) % n) != 0;
    endfunction

    function automatic logic [63:0] mdl_load(input logic [63:0] a, input logic [1:0] s,
                                             input logic u);
        int n = 1 << s;
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl_mem[int'(a[6:0]) + i];
        if (n < 8 && !u && v[8*n-1]) begin
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_pend  <= 1'b0;
            mdl_rdata <= 64'd0;
            mdl_mis   <= 1'b0;
        end else if (mdl_pend) begin
            if (bus.resp_ready) mdl_pend <= 1'b0;
        end else if (bus.req_valid) begin
            mdl_pend <= 1'b1;
            if (mdl_misaligned(bus.req_addr, bus.req_size)) begin
                mdl_mis   <= 1'b1;
                mdl_rdata <= 64'd0;
            end else if (bus.req_wen) begin
                mdl_mis   <= 1'b0;
                mdl_rdata <= 64'd0;
                for (int i = 0; i < (1 << bus.req_size); i++) begin
                    mdl_mem[int'(bus.req_addr[6:0]) + i] <= bus.req_wdata[8*i +: 8];
                end
            end else begin
                mdl_mis   <= 1'b0;
                mdl_rdata <= mdl_load(bus.req_addr, bus.req_size, bus.req_unsigned);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic        exp_en;
        logic [63:0] exp_m;
        logic [63:0] exp_d;
        int          n;
        int          off;
        if (!rst) begin
            chk("req_ready", 64'(bus.req_ready), 64'(!mdl_pend));
            chk("resp_valid", 64'(bus.resp_valid), 64'(mdl_pend));
            if (mdl_pend) begin
                chk("resp_rdata", bus.resp_rdata, mdl_rdata);
                chk("resp_misalign", 64'(bus.resp_misalign), 64'(mdl_mis));
            end
            exp_en = bus.req_valid && !mdl_pend && !mdl_misaligned(bus.req_addr, bus.req_size);
            n      = 1 << bus.req_size;
            off    = int'(bus.req_addr[2:0]);
            exp_m  = 64'd0;
            exp_d  = 64'd0;
            for (int i = 0; i < 8; i++) begin
                if (exp_en && i >= off && i < off + n) begin
                    exp_m[8*i +: 8] = 8'hFF;
                    exp_d[8*i +: 8] = bus.req_wdata[8*(i-off) +: 8];
                end
            end
            chk("dmem_en", 64'(dmem_en), 64'(exp_en));
            chk("dmem_wen", 64'(dmem_wen), 64'(exp_en && bus.req_wen));
            chk("dmem_wmask", dmem_wmask, exp_m);
            chk("dmem_wdata", dmem_wdata, exp_d);
            if (exp_en) chk("dmem_addr", dmem_addr, bus.req_addr);
        end
    end

    logic        cap_en;
    logic        cap_wen;
    logic [63:0] cap_mask;
    logic [63:0] cap_wdata;

    task automatic set_req(input logic [63:0] a, input logic [63:0] wd, input logic we,
                           input logic [1:0] sz, input logic un);
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_wen      = we;
        bus.req_size     = sz;
        bus.req_unsigned = un;
    endtask

    // One request with resp_ready high; returns #1 after the edge that retires the response
    task automatic do_req(input logic [63:0] a, input logic [63:0] wd, input logic we,
                          input logic [1:0] sz, input logic un,
                          output logic [63:0] rd, output logic mis);
        int t = 0;
        set_req(a, wd, we, sz, un);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) chk("accept_timeout", 64'd0, 64'd1);
        cap_en    = dmem_en;
        cap_wen   = dmem_wen;
        cap_mask  = dmem_wmask;
        cap_wdata = dmem_wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rd  = bus.resp_rdata;
        mis = bus.resp_misalign;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic        mis;
        bus.req_valid    = 1'b0;
        bus.req_addr     = 64'd0;
        bus.req_wdata    = 64'd0;
        bus.req_wen      = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.resp_ready   = 1'b1;

        #23;
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_resp_misalign", 64'(bus.resp_misalign), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Byte store into lane 3
        do_req(64'h8000_0003, 64'h11AB, 1'b1, 2'd0, 1'b0, rd, mis);
        chk("sb_wen", 64'(cap_wen), 64'd1);
        chk("sb_wmask", cap_mask, 64'h0000_0000_FF00_0000);
        chk("sb_wdata", cap_wdata, 64'h0000_0000_AB00_0000);
        chk("sb_rdata", rd, 64'd0);

        do_req(64'h8000_0003, 64'd0, 1'b0, 2'd0, 1'b0, rd, mis);
        chk("lb_signed", rd, 64'hFFFF_FFFF_FFFF_FFAB);
        do_req(64'h8000_0003, 64'd0, 1'b0, 2'd0, 1'b1, rd, mis);
        chk("lbu", rd, 64'h0000_0000_0000_00AB);

        do_req(64'h8000_0000, 64'h8000_0001_1234_5678, 1'b1, 2'd3, 1'b0, rd, mis);
        chk("sd_wmask", cap_mask, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(64'h8000_0004, 64'd0, 1'b0, 2'd2, 1'b0, rd, mis);
        chk("lw_signed", rd, 64'hFFFF_FFFF_8000_0001);
        do_req(64'h8000_0004, 64'd0, 1'b0, 2'd2, 1'b1, rd, mis);
        chk("lwu", rd, 64'h0000_0000_8000_0001);
        do_req(64'h8000_0006, 64'd0, 1'b0, 2'd1, 1'b0, rd, mis);
        chk("lh_signed", rd, 64'hFFFF_FFFF_FFFF_8000);

        // Misaligned load and store
        do_req(64'h8000_0002, 64'd0, 1'b0, 2'd2, 1'b0, rd, mis);
        chk("mis_lw_en", 64'(cap_en), 64'd0);
        chk("mis_lw_flag", 64'(mis), 64'd1);
        chk("mis_lw_rdata", rd, 64'd0);
        do_req(64'h8000_0001, 64'hFFFF, 1'b1, 2'd1, 1'b0, rd, mis);
        chk("mis_sh_en", 64'(cap_en), 64'd0);
        chk("mis_sh_flag", 64'(mis), 64'd1);
        do_req(64'h8000_0000, 64'd0, 1'b0, 2'd3, 1'b0, rd, mis);
        chk("mis_sh_intact", rd, 64'h8000_0001_1234_5678);

        // Backpressure with a second request waiting
        set_req(64'h8000_0000, 64'd0, 1'b0, 2'd3, 1'b0);
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1 set_req(64'h8000_0007, 64'd0, 1'b0, 2'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("bp_rdata", bus.resp_rdata, 64'h8000_0001_1234_5678);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_dmem_en", 64'(dmem_en), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_accept_ready", 64'(bus.req_ready), 64'd1);
        chk("bp_accept_en", 64'(dmem_en), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_rdata", bus.resp_rdata, 64'h0000_0000_0000_0080);
        @(posedge clk);
        #1;

        // Sweep every aligned size/offset: store then signed and unsigned reads
        for (int s = 0; s < 4; s++) begin
            for (int o = 0; o < 8; o += (1 << s)) begin
                do_req(64'h8000_0020 + 64'(o), 64'hF0E1_D2C3_B4A5_9687 ^ 64'(o * 8'h11 + s),
                       1'b1, 2'(s), 1'b0, rd, mis);
                do_req(64'h8000_0020 + 64'(o), 64'd0, 1'b0, 2'(s), 1'b0, rd, mis);
                do_req(64'h8000_0020 + 64'(o), 64'd0, 1'b0, 2'(s), 1'b1, rd, mis);
            end
        end

        // Reset while a response is pending
        do_req(64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 2'd3, 1'b0, rd, mis);
        set_req(64'h8000_0008, 64'd0, 1'b0, 2'd3, 1'b0);
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rr_pending", 64'(bus.resp_valid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rr_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rr_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rr_resp_misalign", 64'(bus.resp_misalign), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("rr_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        do_req(64'h8000_0008, 64'd0, 1'b0, 2'd3, 1'b0, rd, mis);
        chk("rr_store_intact", rd, 64'hDEAD_BEEF_CAFE_F00D);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
